// File: rtl/snn_pkg.sv
// Shared constants and arithmetic helpers for the LIF neuron layer.
package snn_pkg;

  localparam int unsigned DEF_M  = 8;
  localparam int unsigned DEF_N  = 4;
  localparam int unsigned DEF_W  = 4;
  localparam int unsigned DEF_P  = 8;
  localparam int unsigned DEF_DW = 3;
  localparam int unsigned DEF_CW = 8;

  localparam logic RESET_ZERO = 1'b0;
  localparam logic RESET_SUB  = 1'b1;

  // Add two values and clamp the result into a p-bit signed range (p <= 31).
  function automatic int sat_add(int a, int b, int unsigned p);
    int s;
    int hi;
    int lo;
    s  = a + b;
    hi = (1 << (p - 1)) - 1;
    lo = -(1 << (p - 1));
    if (s > hi) begin
      return hi;
    end else if (s < lo) begin
      return lo;
    end
    return s;
  endfunction

  // Move v towards zero by decay without crossing zero.
  function automatic int leak(int v, int decay);
    if (v > decay) begin
      return v - decay;
    end else if (v < -decay) begin
      return v + decay;
    end
    return 0;
  endfunction

endpackage

// File: rtl/snn_neuron_layer_param_if.sv
// Control, stimulus and readout bundle of the neuron layer.
interface snn_neuron_layer_param_if
  import snn_pkg::*;
#(
  parameter int unsigned M  = DEF_M,
  parameter int unsigned N  = DEF_N,
  parameter int unsigned W  = DEF_W,
  parameter int unsigned P  = DEF_P,
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned CW = DEF_CW
);

  logic              enable;
  logic              delay_tick;
  logic [M-1:0]      input_spikes;
  logic [N*M*W-1:0]  weights;
  logic [N*M*DW-1:0] delay_values;
  logic [N*M-1:0]    delay_en;
  logic [P-2:0]      threshold;
  logic [P-2:0]      decay;
  logic [CW-1:0]     refractory_period;
  logic              reset_mode;
  logic              count_clear;
  logic [N*P-1:0]    membrane_potential_out;
  logic [N*CW-1:0]   spike_count;
  logic [N-1:0]      output_spikes;

  modport master (
    output enable, delay_tick, input_spikes, weights, delay_values, delay_en,
           threshold, decay, refractory_period, reset_mode, count_clear,
    input  membrane_potential_out, spike_count, output_spikes
  );

  modport slave (
    input  enable, delay_tick, input_spikes, weights, delay_values, delay_en,
           threshold, decay, refractory_period, reset_mode, count_clear,
    output membrane_potential_out, spike_count, output_spikes
  );

endinterface

// File: rtl/snn_lif_neuron.sv
// One leaky integrate-and-fire neuron: sum, leak, saturation, threshold,
// refractory hold and saturating spike counter.
module snn_lif_neuron
  import snn_pkg::*;
#(
  parameter int unsigned M  = DEF_M,
  parameter int unsigned W  = DEF_W,
  parameter int unsigned P  = DEF_P,
  parameter int unsigned CW = DEF_CW
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable_i,
  input  logic [M-1:0]        eff_i,
  input  logic [M*W-1:0]      weights_i,
  input  logic [P-2:0]        threshold_i,
  input  logic [P-2:0]        decay_i,
  input  logic [CW-1:0]       refr_period_i,
  input  logic                reset_mode_i,
  input  logic                count_clear_i,
  output logic signed [P-1:0] v_o,
  output logic [CW-1:0]       count_o,
  output logic                spike_o
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic signed [P-1:0] v_q, v_d;
  logic [CW-1:0]       refr_q, refr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                spike_q, spike_d;
  int                  syn_c;
  int                  v_next_c;

  // Next potential, refractory, spike and counter state.
  always_comb begin
    syn_c    = 0;
    v_d      = v_q;
    refr_d   = refr_q;
    cnt_d    = cnt_q;
    spike_d  = 1'b0;
    for (int unsigned m = 0; m < M; m++) begin
      if (eff_i[m]) begin
        syn_c = syn_c + int'($signed(weights_i[m*W +: W]));
      end
    end
    v_next_c = sat_add(leak(int'(v_q), int'(decay_i)), syn_c, P);
    if (enable_i) begin
      if (refr_q != '0) begin
        refr_d = refr_q - CW'(1);
      end else if (v_next_c >= int'(threshold_i)) begin
        spike_d = 1'b1;
        refr_d  = refr_period_i;
        if (reset_mode_i == RESET_SUB) begin
          v_d = P'(v_next_c - int'(threshold_i));
        end else begin
          v_d = '0;
        end
      end else begin
        v_d = P'(v_next_c);
      end
      // Clear wins over a coincident firing.
      if (count_clear_i) begin
        cnt_d = '0;
      end else if (spike_d && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Neuron state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q     <= '0;
      refr_q  <= '0;
      cnt_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      v_q     <= v_d;
      refr_q  <= refr_d;
      cnt_q   <= cnt_d;
      spike_q <= spike_d;
    end
  end

  assign v_o     = v_q;
  assign count_o = cnt_q;
  assign spike_o = spike_q;

endmodule

// File: rtl/snn_neuron_layer_param.sv
// Layer of N LIF neurons sharing one delayed input spike history.
module snn_neuron_layer_param
  import snn_pkg::*;
#(
  parameter int unsigned M  = DEF_M,
  parameter int unsigned N  = DEF_N,
  parameter int unsigned W  = DEF_W,
  parameter int unsigned P  = DEF_P,
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned CW = DEF_CW
) (
  input logic                    clk,
  input logic                    reset_n,
  snn_neuron_layer_param_if.slave bus
);

  localparam int unsigned DEPTH = (1 << DW) - 1;

  logic [DEPTH-1:0] hist_q [M];
  logic [DEPTH-1:0] hist_d [M];
  logic [N*M-1:0]   eff_c;
  logic [DW-1:0]    dv_c;
  logic [N*P-1:0]   v_all;
  logic [N*CW-1:0]  cnt_all;
  logic [N-1:0]     spk_all;

  // Shift each line's history on an enabled delay tick; newest at bit 0.
  always_comb begin
    for (int unsigned m = 0; m < M; m++) begin
      hist_d[m] = hist_q[m];
      if (bus.enable && bus.delay_tick) begin
        hist_d[m] = DEPTH'({hist_q[m], bus.input_spikes[m]});
      end
    end
  end

  // History registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned m = 0; m < M; m++) begin
        hist_q[m] <= '0;
      end
    end else begin
      for (int unsigned m = 0; m < M; m++) begin
        hist_q[m] <= hist_d[m];
      end
    end
  end

  // Per-synapse tap select: direct input or delayed history bit.
  always_comb begin
    eff_c = '0;
    dv_c  = '0;
    for (int unsigned n = 0; n < N; n++) begin
      for (int unsigned m = 0; m < M; m++) begin
        dv_c = bus.delay_values[(n*M+m)*DW +: DW];
        if (!bus.delay_en[n*M+m] || (dv_c == '0)) begin
          eff_c[n*M+m] = bus.input_spikes[m];
        end else begin
          eff_c[n*M+m] = hist_q[m][dv_c - DW'(1)];
        end
      end
    end
  end

  for (genvar gn = 0; gn < N; gn++) begin : g_neuron
    snn_lif_neuron #(
      .M  (M),
      .W  (W),
      .P  (P),
      .CW (CW)
    ) u_neuron (
      .clk           (clk),
      .reset_n       (reset_n),
      .enable_i      (bus.enable),
      .eff_i         (eff_c[gn*M +: M]),
      .weights_i     (bus.weights[gn*M*W +: M*W]),
      .threshold_i   (bus.threshold),
      .decay_i       (bus.decay),
      .refr_period_i (bus.refractory_period),
      .reset_mode_i  (bus.reset_mode),
      .count_clear_i (bus.count_clear),
      .v_o           (v_all[gn*P +: P]),
      .count_o       (cnt_all[gn*CW +: CW]),
      .spike_o       (spk_all[gn])
    );
  end

  assign bus.membrane_potential_out = v_all;
  assign bus.spike_count            = cnt_all;
  assign bus.output_spikes          = spk_all;

endmodule

// File: tb/tb_snn_neuron_layer_param.sv
// Self-checking bench: behavioural layer model compared every cycle, plus
// hand-computed literal expectations for the directed scenarios.
module tb_snn_neuron_layer_param;

  localparam int M     = 8;
  localparam int N     = 4;
  localparam int W     = 4;
  localparam int P     = 8;
  localparam int DW    = 3;
  localparam int CW    = 8;
  localparam int DEPTH = 7;
  localparam int CMAX  = 255;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  snn_neuron_layer_param_if #(.M(M), .N(N), .W(W), .P(P), .DW(DW), .CW(CW)) bus ();

  snn_neuron_layer_param #(.M(M), .N(N), .W(W), .P(P), .DW(DW), .CW(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int           mv    [N];
  int           mrefr [N];
  int           mcnt  [N];
  bit           mspk  [N];
  logic [M-1:0] mhist [$];
  logic [M-1:0] in_v;
  int           s_sum;
  int           vn;
  int           thr;

  function automatic int wval(int n, int m);
    return int'($signed(bus.weights[(n*M+m)*W +: W]));
  endfunction

  function automatic bit eff(int n, int m, logic [M-1:0] inv);
    int d;
    d = int'(bus.delay_values[(n*M+m)*DW +: DW]);
    if (!bus.delay_en[n*M+m] || d == 0) return inv[m];
    if (d - 1 < mhist.size()) return mhist[d-1][m];
    return 1'b0;
  endfunction

  function automatic int mleak(int v, int dec);
    if (v > dec) return v - dec;
    if (v < -dec) return v + dec;
    return 0;
  endfunction

  function automatic int clampp(int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < N; n++) begin
        mv[n] = 0; mrefr[n] = 0; mcnt[n] = 0; mspk[n] = 0;
      end
      mhist.delete();
    end else if (bus.enable) begin
      in_v = bus.input_spikes;
      thr  = int'(bus.threshold);
      for (int n = 0; n < N; n++) begin
        mspk[n] = 0;
        if (mrefr[n] > 0) begin
          mrefr[n] = mrefr[n] - 1;
        end else begin
          s_sum = 0;
          for (int m = 0; m < M; m++) if (eff(n, m, in_v)) s_sum += wval(n, m);
          vn = clampp(mleak(mv[n], int'(bus.decay)) + s_sum);
          if (vn >= thr) begin
            mspk[n]  = 1;
            mrefr[n] = int'(bus.refractory_period);
            mv[n]    = bus.reset_mode ? vn - thr : 0;
          end else begin
            mv[n] = vn;
          end
        end
        if (bus.count_clear) mcnt[n] = 0;
        else if (mspk[n] && mcnt[n] < CMAX) mcnt[n] = mcnt[n] + 1;
      end
      if (bus.delay_tick) begin
        mhist.push_front(in_v);
        if (mhist.size() > DEPTH) void'(mhist.pop_back());
      end
    end else begin
      for (int n = 0; n < N; n++) mspk[n] = 0;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_v(int n);
    return int'($signed(bus.membrane_potential_out[n*P +: P]));
  endfunction

  function automatic int dut_c(int n);
    return int'(bus.spike_count[n*CW +: CW]);
  endfunction

  function automatic int dut_s(int n);
    return int'(bus.output_spikes[n]);
  endfunction

  always @(negedge clk) begin
    for (int n = 0; n < N; n++) begin
      chk($sformatf("model_v%0d", n), dut_v(n), mv[n]);
      chk($sformatf("model_cnt%0d", n), dut_c(n), mcnt[n]);
      chk($sformatf("model_spk%0d", n), dut_s(n), int'(mspk[n]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic set_w(int n, int m, int v);
    bus.weights[(n*M+m)*W +: W] = W'(v);
  endtask

  task automatic set_d(int n, int m, bit en, int d);
    bus.delay_en[n*M+m] = en;
    bus.delay_values[(n*M+m)*DW +: DW] = DW'(d);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n               = 1'b0;
    bus.enable            = 1'b0;
    bus.delay_tick        = 1'b0;
    bus.input_spikes      = '0;
    bus.weights           = '0;
    bus.delay_values      = '0;
    bus.delay_en          = '0;
    bus.threshold         = 7'd10;
    bus.decay             = '0;
    bus.refractory_period = '0;
    bus.reset_mode        = 1'b0;
    bus.count_clear       = 1'b0;
    step(3);
    reset_n = 1'b1;
    step(1);
    chk("reset_v0", dut_v(0), 0);
    chk("reset_spikes", int'(bus.output_spikes), 0);
    chk("reset_counts", int'(bus.spike_count), 0);

    // Integrate and fire, zero-reset mode.
    set_w(0, 0, 3);
    bus.input_spikes = 8'h01;
    bus.enable       = 1'b1;
    step(1); chk("if_v1", dut_v(0), 3);
    step(1); chk("if_v2", dut_v(0), 6);
    step(1); chk("if_v3", dut_v(0), 9); chk("if_nospk", dut_s(0), 0);
    step(1); chk("if_fire_v", dut_v(0), 0); chk("if_fire_s", dut_s(0), 1);

    // Subtract mode.
    bus.reset_mode = 1'b1;
    step(3); chk("sub_v9", dut_v(0), 9);
    step(1); chk("sub_fire_v", dut_v(0), 2); chk("sub_fire_s", dut_s(0), 1);
    step(2); chk("sub_v8", dut_v(0), 8);
    step(1); chk("sub_fire2_v", dut_v(0), 1); chk("sub_fire2_s", dut_s(0), 1);
    chk("sub_cnt", dut_c(0), 3);

    // Drain potential and flush history before the delay test.
    bus.reset_mode   = 1'b0;
    bus.input_spikes = '0;
    bus.decay        = 7'd1;
    bus.delay_tick   = 1'b1;
    step(8);
    bus.decay     = '0;
    bus.threshold = 7'd1;
    set_d(0, 0, 1'b1, 5);
    set_w(1, 0, 2);
    set_d(1, 0, 1'b1, 7);
    bus.input_spikes = 8'h01;
    step(1);
    bus.input_spikes = '0;
    chk("dly_t0_s0", dut_s(0), 0);
    for (int k = 1; k <= 7; k++) begin
      step(1);
      chk($sformatf("dly5_t%0d", k), dut_s(0), (k == 5) ? 1 : 0);
      chk($sformatf("dly7_t%0d", k), dut_s(1), (k == 7) ? 1 : 0);
    end
    chk("dly_cnt0", dut_c(0), 4);

    // Refractory hold with an enable gap.
    bus.delay_en          = '0;
    bus.delay_tick        = 1'b0;
    bus.threshold         = 7'd10;
    bus.refractory_period = 8'd3;
    bus.input_spikes      = 8'h01;
    step(3); chk("ref_v9", dut_v(0), 9);
    step(1); chk("ref_fire_s", dut_s(0), 1); chk("ref_cnt", dut_c(0), 5);
    step(1); chk("ref_hold1", dut_v(0), 0); chk("ref_hold1_s", dut_s(0), 0);
    bus.enable = 1'b0;
    step(2); chk("ref_dis_v", dut_v(0), 0); chk("ref_dis_s", dut_s(0), 0);
    bus.enable = 1'b1;
    step(1); chk("ref_hold2", dut_v(0), 0);
    step(1); chk("ref_hold3", dut_v(0), 0);
    step(1); chk("ref_resume", dut_v(0), 3);

    // Negative saturation, then leak back towards zero.
    for (int m = 0; m < M; m++) set_w(2, m, -8);
    bus.threshold    = 7'd127;
    bus.input_spikes = 8'hFF;
    step(1); chk("sat_v1", dut_v(2), -64);
    step(1); chk("sat_v2", dut_v(2), -128);
    step(1); chk("sat_v3", dut_v(2), -128);
    bus.input_spikes = '0;
    bus.decay        = 7'd20;
    step(1); chk("leak_v1", dut_v(2), -108);
    step(1); chk("leak_v2", dut_v(2), -88);

    // Counter saturation with threshold 0, clear priority, async reset.
    bus.decay             = '0;
    bus.threshold         = '0;
    bus.refractory_period = '0;
    bus.input_spikes      = 8'h01;
    set_w(3, 0, 1);
    step(300);
    chk("cnt_sat", dut_c(3), 255);
    chk("cnt_sat_spk", dut_s(3), 1);
    bus.count_clear = 1'b1;
    step(1); chk("cnt_clr", dut_c(3), 0); chk("cnt_clr_spk", dut_s(3), 1);
    bus.count_clear = 1'b0;
    step(1); chk("cnt_after_clr", dut_c(3), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_v", int'(bus.membrane_potential_out), 0);
    chk("arst_cnt", int'(bus.spike_count), 0);
    chk("arst_spk", int'(bus.output_spikes), 0);
    step(2);
    reset_n = 1'b1;
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
